// File: rtl/fcs_check_sequencer.sv
// Front-end sequencer for the byte-serial FCS checker: four-byte delay line,
// start/end framing pulses, verdict sampling and one status record per frame.
//
// state | meaning
// IDLE  | waiting for byte 0 of a frame
// RECV  | accepting frame bytes into the delay line
// DRAIN | flushing the delay line, raising end-of-frame, waiting for the verdict
// GAP   | one-cycle status publish, input held off
module fcs_check_sequencer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        chk_start_of_frame,
    output logic        chk_end_of_frame,
    output logic [7:0]  chk_data,
    input  logic        chk_fcs_error,
    output logic        res_valid,
    output logic        res_ok,
    output logic        res_fcs_err,
    output logic        res_runt,
    output logic        res_giant,
    output logic        res_abort,
    output logic [15:0] res_len
);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN, GAP} state_t;

    localparam logic [15:0] MIN_L = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L = 16'(MAX_LEN);

    state_t           state_q, state_d;
    logic [3:0][7:0]  dly_q, dly_d;
    logic [3:0]       sof_q, sof_d;
    logic [15:0]      len_q, len_d;
    logic [2:0]       floor_q, floor_d;
    logic [1:0]       tmr_q, tmr_d;
    logic             eof_seen_q, eof_seen_d;
    logic             abort_q, abort_d;
    logic             ok_q, ok_d, fe_q, fe_d, runt_q, runt_d;
    logic             giant_q, giant_d, ab_q, ab_d;
    logic [15:0]      rlen_q, rlen_d;
    logic             eof_fire, is_runt, is_giant, fe_eff;

    assign is_runt  = len_q < MIN_L;
    assign is_giant = len_q > MAX_L;
    assign fe_eff   = chk_fcs_error & ~is_runt & ~abort_q;

    always_comb begin
        state_d    = state_q;
        dly_d      = {dly_q[2:0], 8'h00};
        sof_d      = {sof_q[2:0], 1'b0};
        len_d      = len_q;
        floor_d    = (floor_q != 3'd0) ? floor_q - 3'd1 : floor_q;
        tmr_d      = (tmr_q != 2'd0) ? tmr_q - 2'd1 : tmr_q;
        eof_seen_d = eof_seen_q;
        abort_d    = abort_q;
        ok_d       = ok_q;
        fe_d       = fe_q;
        runt_d     = runt_q;
        giant_d    = giant_q;
        ab_d       = ab_q;
        rlen_d     = rlen_q;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        eof_fire   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dly_d[0]   = in_data;
                    sof_d[0]   = 1'b1;
                    len_d      = 16'd1;
                    // floor_q reaches zero at t0+8, the earliest legal end-of-frame
                    floor_d    = 3'd7;
                    eof_seen_d = 1'b0;
                    abort_d    = 1'b0;
                    state_d    = in_last ? DRAIN : RECV;
                end
            end
            RECV: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    dly_d[0] = in_data;
                    if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
                    if (in_last) state_d = DRAIN;
                end else begin
                    abort_d  = 1'b1;
                    eof_fire = (floor_q == 3'd0);
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                eof_fire = ~eof_seen_q & (floor_q == 3'd0);
                if (eof_seen_q && tmr_q == 2'd0) begin
                    fe_d    = fe_eff;
                    runt_d  = is_runt;
                    giant_d = is_giant;
                    ab_d    = abort_q;
                    ok_d    = ~(fe_eff | is_runt | is_giant | abort_q);
                    rlen_d  = len_q;
                    state_d = GAP;
                end
            end
            GAP: begin
                res_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (eof_fire) begin
            eof_seen_d = 1'b1;
            tmr_d      = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            dly_q      <= '0;
            sof_q      <= '0;
            len_q      <= '0;
            floor_q    <= '0;
            tmr_q      <= '0;
            eof_seen_q <= 1'b0;
            abort_q    <= 1'b0;
            ok_q       <= 1'b0;
            fe_q       <= 1'b0;
            runt_q     <= 1'b0;
            giant_q    <= 1'b0;
            ab_q       <= 1'b0;
            rlen_q     <= '0;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            sof_q      <= sof_d;
            len_q      <= len_d;
            floor_q    <= floor_d;
            tmr_q      <= tmr_d;
            eof_seen_q <= eof_seen_d;
            abort_q    <= abort_d;
            ok_q       <= ok_d;
            fe_q       <= fe_d;
            runt_q     <= runt_d;
            giant_q    <= giant_d;
            ab_q       <= ab_d;
            rlen_q     <= rlen_d;
        end
    end

    assign chk_start_of_frame = sof_q[3];
    assign chk_end_of_frame   = eof_fire;
    assign chk_data           = dly_q[3];
    assign res_ok             = ok_q;
    assign res_fcs_err        = fe_q;
    assign res_runt           = runt_q;
    assign res_giant          = giant_q;
    assign res_abort          = ab_q;
    assign res_len            = rlen_q;

endmodule

// File: tb/tb_fcs_check_sequencer.sv
// Bench for fcs_check_sequencer: timestamp-based frame model (S, E, tL) predicts
// every output each cycle; the bench also plays the checker's verdict.
module tb_fcs_check_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        chk_fcs_error = 1'b0;
    logic        in_ready, chk_start_of_frame, chk_end_of_frame, res_valid;
    logic [7:0]  chk_data;
    logic        res_ok, res_fcs_err, res_runt, res_giant, res_abort;
    logic [15:0] res_len;

    fcs_check_sequencer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .chk_start_of_frame(chk_start_of_frame), .chk_end_of_frame(chk_end_of_frame),
        .chk_data(chk_data), .chk_fcs_error(chk_fcs_error),
        .res_valid(res_valid), .res_ok(res_ok), .res_fcs_err(res_fcs_err),
        .res_runt(res_runt), .res_giant(res_giant), .res_abort(res_abort), .res_len(res_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       bad;
    } item_t;

    item_t       q[$];
    int          c, cmp, fails;
    int          t0s[$], sofs[$], eofs[$], rvs[$];
    logic [7:0]  saved [0:63];

    // frame record: start cycle, byte count, end known, cycle the end became known, E
    bit          m_act, m_end, m_ab, m_bad;
    int          m_t0, m_n, m_endc, m_e;
    logic [7:0]  mb [0:2047];
    logic        es_ok, es_fe, es_runt, es_giant, es_ab;
    logic [15:0] es_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        cmp++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, expv);
        end
    endtask

    function automatic int ev_rel(input int kind, input int idx, input int base);
        int n;
        n = (kind == 0) ? sofs.size() : (kind == 1) ? eofs.size() : rvs.size();
        if (idx >= n) return -1;
        if (kind == 0) return sofs[idx] - base;
        if (kind == 1) return eofs[idx] - base;
        return rvs[idx] - base;
    endfunction

    function automatic int t0_of(input int i);
        return (i < t0s.size()) ? t0s[i] : -100000;
    endfunction

    task automatic clear_obs();
        t0s.delete(); sofs.delete(); eofs.delete(); rvs.delete();
    endtask

    task automatic push_idle(input int n);
        item_t it;
        it = '0;
        for (int i = 0; i < n; i++) q.push_back(it);
    endtask

    task automatic push_frame(input int len, input bit ab, input bit bad, input bit reuse);
        item_t it;
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = (reuse && i < 64) ? saved[i] : 8'($urandom);
            if (reuse && bad && i == 20) d[3] = ~d[3];
            if (!reuse && i < 64) saved[i] = d;
            it.v = 1'b1; it.d = d; it.l = !ab && (i == len - 1); it.bad = bad;
            q.push_back(it);
        end
        if (ab) push_idle(1);
    endtask

    task automatic step(input bit rst_lvl);
        item_t it;
        bit er, acc, have, esof, eeof, erv;
        int k;
        logic [7:0] ed;
        @(posedge clk);
        #1;
        c++;
        if (!rst_lvl) begin
            q.delete();
            m_act = 0; m_end = 0;
            {es_ok, es_fe, es_runt, es_giant, es_ab} = '0;
            es_len = '0;
        end
        reset_n = rst_lvl;
        er = !(m_act && m_end && c > m_endc && c <= m_e + 5);
        have = (q.size() > 0);
        it = have ? q[0] : '0;
        in_valid = it.v;
        in_data  = it.v ? it.d : 8'($urandom);
        in_last  = it.v & it.l;
        acc = it.v && er;
        if (m_act && !m_end && !it.v) begin
            m_end = 1; m_ab = 1; m_endc = c;
            m_e = (c > m_t0 + 8) ? c : m_t0 + 8;
        end else if (acc) begin
            if (!(m_act && !m_end)) begin
                m_act = 1; m_end = 0; m_ab = 0; m_t0 = c; m_n = 0; m_bad = it.bad;
                t0s.push_back(c);
            end
            mb[m_n] = it.d;
            m_n++;
            if (it.l) begin
                m_end = 1; m_endc = c;
                m_e = (c + 1 > m_t0 + 8) ? c + 1 : m_t0 + 8;
            end
        end
        if (have && (!it.v || acc)) void'(q.pop_front());
        chk_fcs_error = (m_act && m_end && c == m_e + 4) ? m_bad : 1'($urandom);

        esof = m_act && (c == m_t0 + 4);
        eeof = m_act && m_end && (c == m_e);
        erv  = m_act && m_end && (c == m_e + 5);
        k    = c - (m_t0 + 4);
        ed   = (m_act && k >= 0 && k < m_n) ? mb[k] : 8'h00;
        if (erv) begin
            es_len   = 16'((m_n > 65535) ? 65535 : m_n);
            es_runt  = (m_n < 64);
            es_giant = (m_n > 1518);
            es_ab    = m_ab;
            es_fe    = m_bad && !es_runt && !m_ab;
            es_ok    = !(es_fe || es_runt || es_giant || es_ab);
        end

        @(negedge clk);
        if (chk_start_of_frame === 1'b1) sofs.push_back(c);
        if (chk_end_of_frame === 1'b1) eofs.push_back(c);
        if (res_valid === 1'b1) rvs.push_back(c);
        chk("in_ready",  32'(in_ready),           32'(er));
        chk("sof",       32'(chk_start_of_frame), 32'(esof));
        chk("eof",       32'(chk_end_of_frame),   32'(eeof));
        chk("chk_data",  32'(chk_data),           32'(ed));
        chk("res_valid", 32'(res_valid),          32'(erv));
        chk("res_ok",    32'(res_ok),             32'(es_ok));
        chk("res_fcs",   32'(res_fcs_err),        32'(es_fe));
        chk("res_runt",  32'(res_runt),           32'(es_runt));
        chk("res_giant", 32'(res_giant),          32'(es_giant));
        chk("res_abort", 32'(res_abort),          32'(es_ab));
        chk("res_len",   32'(res_len),            32'(es_len));
    endtask

    task automatic run_until_done(input int max_cyc);
        int i;
        i = 0;
        while ((q.size() > 0 || (m_act && !(m_end && c > m_e + 5))) && i < max_cyc) begin
            step(1'b1);
            i++;
        end
        chk("run_timeout", 32'(i < max_cyc), 32'(1));
    endtask

    initial begin
        int nf, i;
        cmp = 0; fails = 0; c = 0;
        m_act = 0; m_end = 0; m_ab = 0; m_bad = 0;
        m_t0 = 0; m_n = 0; m_endc = 0; m_e = 0;
        {es_ok, es_fe, es_runt, es_giant, es_ab} = '0;
        es_len = '0;

        step(1'b0);
        step(1'b0);
        push_idle(2);
        run_until_done(10);

        // 64-byte good frame
        clear_obs();
        push_frame(64, 1'b0, 1'b0, 1'b0);
        run_until_done(200);
        chk("t1_sof_rel", 32'(ev_rel(0, 0, t0_of(0))), 32'(4));
        chk("t1_eof_rel", 32'(ev_rel(1, 0, t0_of(0))), 32'(64));
        chk("t1_rv_rel",  32'(ev_rel(2, 0, t0_of(0))), 32'(69));
        chk("t1_ok",      32'(res_ok), 32'(1));
        chk("t1_len",     32'(res_len), 32'(64));

        // same frame, one bit flipped
        clear_obs();
        push_idle(3);
        push_frame(64, 1'b0, 1'b1, 1'b1);
        run_until_done(200);
        chk("t2_rv_rel",  32'(ev_rel(2, 0, t0_of(0))), 32'(69));
        chk("t2_fcs",     32'(res_fcs_err), 32'(1));
        chk("t2_ok",      32'(res_ok), 32'(0));

        // 5-byte runt, checker claims error
        clear_obs();
        push_frame(5, 1'b0, 1'b1, 1'b0);
        run_until_done(100);
        chk("t3_eof_rel", 32'(ev_rel(1, 0, t0_of(0))), 32'(8));
        chk("t3_rv_rel",  32'(ev_rel(2, 0, t0_of(0))), 32'(13));
        chk("t3_runt",    32'(res_runt), 32'(1));
        chk("t3_fcs",     32'(res_fcs_err), 32'(0));
        chk("t3_len",     32'(res_len), 32'(5));

        // abort after byte 39
        clear_obs();
        push_frame(40, 1'b1, 1'b1, 1'b0);
        run_until_done(200);
        chk("t4_eof_rel", 32'(ev_rel(1, 0, t0_of(0))), 32'(40));
        chk("t4_rv_rel",  32'(ev_rel(2, 0, t0_of(0))), 32'(45));
        chk("t4_abort",   32'(res_abort), 32'(1));
        chk("t4_len",     32'(res_len), 32'(40));
        chk("t4_ok",      32'(res_ok), 32'(0));

        // back-to-back with in_valid held high
        clear_obs();
        push_frame(64, 1'b0, 1'b0, 1'b0);
        push_frame(64, 1'b0, 1'b0, 1'b1);
        run_until_done(400);
        chk("t5_t0_gap",  32'(t0_of(1) - t0_of(0)), 32'(70));
        chk("t5_sof2",    32'(ev_rel(0, 1, t0_of(0))), 32'(74));
        chk("t5_nrv",     32'(rvs.size()), 32'(2));
        chk("t5_ok",      32'(res_ok), 32'(1));

        // randomized frames
        clear_obs();
        nf = 6;
        for (int f = 0; f < nf; f++) begin
            push_idle($urandom_range(0, 3));
            push_frame($urandom_range(1, 90), ($urandom_range(0, 3) == 0), 1'($urandom), 1'b0);
        end
        run_until_done(3000);
        chk("rnd_nrv",    32'(rvs.size()), 32'(nf));

        // giant, then reset mid-frame
        clear_obs();
        push_frame(1519, 1'b0, 1'b0, 1'b0);
        run_until_done(2000);
        chk("t6_giant",   32'(res_giant), 32'(1));
        chk("t6_ok",      32'(res_ok), 32'(0));
        clear_obs();
        push_frame(64, 1'b0, 1'b0, 1'b0);
        i = 0;
        while ((t0s.size() == 0 || m_n < 20) && i < 100) begin
            step(1'b1);
            i++;
        end
        chk("t7_reach20", 32'(i < 100), 32'(1));
        step(1'b0);
        step(1'b0);
        for (int j = 0; j < 20; j++) step(1'b1);
        chk("t7_nrv",     32'(rvs.size()), 32'(0));
        chk("t7_ready",   32'(in_ready), 32'(1));
        chk("t7_len",     32'(res_len), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d observed=hang expected=finish", c);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fcs_check_sequencer.md
# fcs_check_sequencer

Front-end controller that sequences the byte-serial FCS checker for one ingress port. It accepts a frame byte stream with valid/last/ready handshaking and delays it four bytes so the first FCS byte can be flagged. It drives the checker's start/end/data inputs, samples the checker's error verdict at the correct cycle and issues one per-frame status record. It sits between the port RX adapter and the switch's frame-admission logic.

## Interface
Parameters:
- MIN_LEN, 64, frames with fewer bytes (FCS included) are runts; legal range 8..65535
- MAX_LEN, 1518, frames with more bytes are giants

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  byte present on in_data
- in_data  in  8  frame byte, destination address first, FCS last
- in_last  in  1  qualifies the last FCS byte
- in_ready  out  1  sequencer accepts a byte when in_valid & in_ready
- chk_start_of_frame  out  1  one-cycle pulse with frame byte 0 on chk_data
- chk_end_of_frame  out  1  one-cycle pulse with first FCS byte on chk_data
- chk_data  out  8  byte stream to the checker
- chk_fcs_error  in  1  checker verdict, valid only in the sample cycle
- res_valid  out  1  one-cycle pulse, status fields valid
- res_ok  out  1  frame good: FCS correct, not runt, not giant, not aborted
- res_fcs_err  out  1  checker reported error; forced 0 if runt or abort
- res_runt  out  1  length < MIN_LEN
- res_giant  out  1  length > MAX_LEN
- res_abort  out  1  in_valid dropped mid-frame
- res_len  out  16  accepted byte count, saturating at 0xFFFF

## Operation
- States: IDLE, RECV, DRAIN, GAP.
- IDLE: in_ready=1. The first accepted byte (t0) starts the frame and moves to RECV. If in_last is also set, N=1 and the block goes straight to DRAIN.
- RECV: in_ready=1. Each accepted byte enters a 4-deep delay line and increments the length counter.
  - Accepted byte with in_last: goes to DRAIN; tL = that cycle.
  - in_valid=0 before in_last: abort; goes to DRAIN; tL = cycle before the gap.
- Delay line: byte k appears on chk_data at S+k, where S = t0+4. Slots not filled from the input drive 0x00. Outside a frame, chk_data = 0x00.
- chk_start_of_frame = 1 at S only.
- chk_end_of_frame = 1 at E only, where E = max(tL+1, S+4).
  - The S+4 floor keeps the checker out of its start-complement window for N<8 and for early aborts.
- DRAIN: in_ready=0. The block feeds the remaining delayed bytes, then zeros, up to E+3. It samples chk_fcs_error at E+4.
- GAP: lasts exactly one cycle, E+5. In this cycle res_valid=1 with all status fields, in_ready=0, then the block returns to IDLE.
- Status arithmetic:
  - res_len = N.
  - res_runt = N<MIN_LEN.
  - res_giant = N>MAX_LEN; comparisons are made on the saturated count.
  - res_ok = ~(res_fcs_err | res_runt | res_giant | res_abort).
- Status fields hold their values until the next res_valid.

## Timing
- Reset values: in_ready=1; every other output is 0; state IDLE; delay line, counters and status cleared.
- Reset asserted mid-frame: the frame is dropped silently, with no res_valid.
- Latencies:
  - Byte latency in to chk_data: 4 cycles.
  - Natural end: E = tL+1.
  - Sample at E+4; res_valid at E+5.
  - Good frame of N≥8 bytes: res_valid at t0+N+5.
- Back-to-back frames: next t0' ≥ E+6, so next S' ≥ E+10. The checker is idle before the next start, guaranteed by in_ready.
- in_valid high while in_ready=0 is ignored, with no byte consumed. The source must hold the byte.
- Length counter saturates at 0xFFFF and never wraps.
- A gap of one or more cycles during RECV always aborts; there is no stall inside a frame.

## Test plan
- 64-byte frame with correct FCS, contiguous:
  - chk_start_of_frame at t0+4, chk_end_of_frame at t0+64, res_valid at t0+69.
  - res_ok=1, res_len=64, all error flags 0.
- Same frame with one payload bit flipped: res_fcs_err=1, res_ok=0, same timing.
- 5-byte frame with in_last on byte 4:
  - chk_end_of_frame at t0+8, not t0+5; chk_data=0x00 after byte 4.
  - res_valid at t0+13 with res_runt=1, res_fcs_err=0, res_len=5.
- 100-byte frame with in_valid dropped after byte 39:
  - res_abort=1, res_len=40, res_ok=0.
  - chk_end_of_frame at t0+40, res_valid at t0+45.
- Two 64-byte frames with in_valid held high:
  - in_ready=0 from t0+64 to t0+69; second frame starts at t0+70.
  - Second S at t0+74; two res_valid pulses, both ok.
- 1519-byte good-FCS frame, then reset_n pulsed at byte 20 of a following frame:
  - First frame: res_giant=1, res_ok=0.
  - After reset: outputs 0, in_ready=1, no res_valid for the dropped frame.
